// File: rtl/sda_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sda_axi_pkg
// Brief    : AXI response codes and engine state encodings for the gmem slave
// Revision : 1.0
// ============================================================================
package sda_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/sda_gmem_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : sda_gmem_ram_dp
// Brief    : Simple dual-port RAM, byte-enable write port, registered
//            read-first read port
// Revision : 1.0
// ============================================================================
module sda_gmem_ram_dp #(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic [DATA_WIDTH/8-1:0]   i_wr_be,
    input  logic [MEM_ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic                      i_rd_en,
    input  logic [MEM_ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0]     o_rd_data
);

    localparam int c_nbytes = DATA_WIDTH / 8;
    localparam int c_depth  = 2 ** MEM_ADDR_WIDTH;

    // One storage array per byte lane keeps each lane's write enable independent.
    for (genvar b = 0; b < c_nbytes; b++) begin : g_lane
        logic [7:0] r_mem [c_depth];
        logic [7:0] r_rd_byte;

        always_ff @(posedge clk) begin
            if (i_wr_be[b]) begin
                r_mem[i_wr_addr] <= i_wr_data[b*8 +: 8];
            end
            if (i_rd_en) begin
                r_rd_byte <= r_mem[i_rd_addr];
            end
        end

        assign o_rd_data[b*8 +: 8] = r_rd_byte;
    end

endmodule
`default_nettype wire

// File: rtl/sda_gmem_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : sda_gmem_slave_mem
// Brief    : AXI4 slave memory on the kernel gmem port, backed by local RAM
// Revision : 1.0
// ============================================================================
module sda_gmem_slave_mem
    import sda_axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 1,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int c_nbytes = DATA_WIDTH / 8;
    localparam int c_lsb    = $clog2(c_nbytes);
    localparam int c_msb    = MEM_ADDR_WIDTH + c_lsb - 1;
    localparam logic [MEM_ADDR_WIDTH-1:0] c_addr_one = MEM_ADDR_WIDTH'(1);

    // ------------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------------
    wr_state_t                 r_wstate;
    wr_state_t                 w_wstate_nxt;
    logic [MEM_ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]                r_wcnt;
    logic [ID_WIDTH-1:0]       r_wid;
    logic                      r_werr;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_wfinal;
    logic [c_nbytes-1:0]       w_ram_be;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        if (!reset) begin
            case (r_wstate)
                W_IDLE: begin
                    s_axi_awready = 1'b1;
                    if (s_axi_awvalid) begin
                        w_wstate_nxt = W_DATA;
                    end
                end
                W_DATA: begin
                    s_axi_wready = 1'b1;
                    if (s_axi_wvalid && w_wfinal) begin
                        w_wstate_nxt = W_RESP;
                    end
                end
                W_RESP: begin
                    s_axi_bvalid = 1'b1;
                    if (s_axi_bready) begin
                        w_wstate_nxt = W_IDLE;
                    end
                end
                default: w_wstate_nxt = W_IDLE;
            endcase
        end
    end

    assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_w_hs   = s_axi_wvalid && s_axi_wready;
    assign w_wfinal = (r_wcnt == 8'd0);
    assign w_ram_be = w_w_hs ? s_axi_wstrb : '0;

    // Burst length is decided by AWLEN alone; WLAST only feeds the error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waddr <= '0;
            r_wcnt  <= '0;
            r_wid   <= '0;
            r_werr  <= 1'b0;
        end else if (w_aw_hs) begin
            r_waddr <= s_axi_awaddr[c_msb:c_lsb];
            r_wcnt  <= s_axi_awlen;
            r_wid   <= s_axi_awid;
            r_werr  <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr <= r_waddr + c_addr_one;
            r_wcnt  <= r_wcnt - 8'd1;
            if (s_axi_wlast != w_wfinal) begin
                r_werr <= 1'b1;
            end
        end
    end

    assign s_axi_bid   = r_wid;
    assign s_axi_bresp = (s_axi_bvalid && r_werr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    // ------------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------------
    rd_state_t                 r_rstate;
    rd_state_t                 w_rstate_nxt;
    logic [MEM_ADDR_WIDTH-1:0] r_raddr;
    logic [8:0]                r_issue_left;
    logic [8:0]                r_load_left;
    logic [ID_WIDTH-1:0]       r_rid;
    logic                      r_p1_valid;
    logic                      r_rvalid;
    logic                      r_rlast;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      w_ar_hs;
    logic                      w_out_free;
    logic                      w_p1_move;
    logic                      w_issue;
    logic                      w_ram_re;
    logic [MEM_ADDR_WIDTH-1:0] w_ram_raddr;
    logic [DATA_WIDTH-1:0]     w_ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        s_axi_arready = 1'b0;
        if (!reset) begin
            case (r_rstate)
                R_IDLE: begin
                    s_axi_arready = 1'b1;
                    if (s_axi_arvalid) begin
                        w_rstate_nxt = R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rvalid && s_axi_rready && r_rlast) begin
                        w_rstate_nxt = R_IDLE;
                    end
                end
                default: w_rstate_nxt = R_IDLE;
            endcase
        end
    end

    // The RAM output register doubles as the skid stage: a read is only issued
    // when its current word has somewhere to go, so it never gets overwritten.
    assign w_ar_hs     = s_axi_arvalid && s_axi_arready;
    assign w_out_free  = !r_rvalid || s_axi_rready;
    assign w_p1_move   = r_p1_valid && w_out_free;
    assign w_issue     = (r_rstate == R_DATA) && (r_issue_left != 9'd0)
                         && (!r_p1_valid || w_out_free);
    assign w_ram_re    = w_ar_hs || w_issue;
    assign w_ram_raddr = w_ar_hs ? s_axi_araddr[c_msb:c_lsb] : r_raddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_raddr      <= '0;
            r_issue_left <= '0;
            r_load_left  <= '0;
            r_rid        <= '0;
            r_p1_valid   <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rlast      <= 1'b0;
            r_rdata      <= '0;
        end else begin
            if (w_ar_hs) begin
                r_raddr      <= s_axi_araddr[c_msb:c_lsb] + c_addr_one;
                r_issue_left <= {1'b0, s_axi_arlen};
                r_load_left  <= {1'b0, s_axi_arlen} + 9'd1;
                r_rid        <= s_axi_arid;
            end else if (w_issue) begin
                r_raddr      <= r_raddr + c_addr_one;
                r_issue_left <= r_issue_left - 9'd1;
            end

            if (w_ram_re) begin
                r_p1_valid <= 1'b1;
            end else if (w_p1_move) begin
                r_p1_valid <= 1'b0;
            end

            if (w_out_free) begin
                r_rvalid <= r_p1_valid;
                if (r_p1_valid) begin
                    r_rdata     <= w_ram_rdata;
                    r_rlast     <= (r_load_left == 9'd1);
                    r_load_left <= r_load_left - 9'd1;
                end
            end
        end
    end

    assign s_axi_rvalid = r_rvalid && !reset;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rlast  = r_rlast;
    assign s_axi_rid    = r_rid;
    assign s_axi_rresp  = AXI_RESP_OKAY;

    // Address bits outside the RAM word index alias onto the same words.
    logic w_unused_addr;
    assign w_unused_addr = ^{s_axi_awaddr[ADDR_WIDTH-1:c_msb+1], s_axi_awaddr[c_lsb-1:0],
                             s_axi_araddr[ADDR_WIDTH-1:c_msb+1], s_axi_araddr[c_lsb-1:0]};

    sda_gmem_ram_dp #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_be   (w_ram_be),
        .i_wr_addr (r_waddr),
        .i_wr_data (s_axi_wdata),
        .i_rd_en   (w_ram_re),
        .i_rd_addr (w_ram_raddr),
        .o_rd_data (w_ram_rdata)
    );

endmodule
`default_nettype wire
